// File: rtl/barrier_pkg.sv
// Shared types and constants for the destructible barrier map.
package barrier_pkg;

  localparam int NUM_BARRIERS = 4;
  localparam int CELL_ROWS    = 8;
  localparam int CELL_COLS    = 10;
  localparam logic [8:0] INIT_COUNT = 9'd248;

  // One barrier: [cell_row][cell_col], bit c of a row is cell column c.
  typedef logic [CELL_ROWS-1:0][CELL_COLS-1:0] barrier_map_t;

  // Initial barrier shape: rounded top, arch cut out of the bottom rows.
  localparam barrier_map_t INIT_MASK = {
    10'b1100000011,  // row 7
    10'b1100000011,  // row 6
    10'b1110000111,  // row 5
    10'b1111111111,  // row 4
    10'b1111111111,  // row 3
    10'b1111111111,  // row 2
    10'b1111111111,  // row 1
    10'b0111111110   // row 0
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ERASE = 2'd2,
    RESP  = 2'd3
  } hit_state_t;

  typedef struct packed {
    logic [1:0] barrier;
    logic [2:0] row;
    logic [3:0] col;
    logic       in_range;
  } cell_addr_t;

  // Number of cells that flip 1->0 on an erase; splash cells only count
  // when the target itself was intact.
  function automatic logic [8:0] erased_cells(input logic tgt, input logic up, input logic dn);
    logic [8:0] n;
    n = 9'd0;
    if (tgt) begin
      n = 9'd1 + {8'd0, up} + {8'd0, dn};
    end else begin
      n = 9'd0;
    end
    return n;
  endfunction

endpackage

// File: rtl/barrier_addr_decode.sv
// Combinational pixel coordinate -> barrier cell address decode.
import barrier_pkg::*;

module barrier_addr_decode #(
  parameter int SPRITE_ROW    = 380,
  parameter int SPRITE_COLUMN = 120,
  parameter int BARRIER_PITCH = 120
) (
  input  logic [11:0] row,
  input  logic [11:0] col,
  output cell_addr_t  addr
);

  logic                    row_hit_s;
  logic [11:0]             row_off_s;
  logic [NUM_BARRIERS-1:0] col_hit_s;
  logic [11:0]             col_off_s [NUM_BARRIERS];

  assign row_hit_s = (32'(row) > SPRITE_ROW) && (32'(row) < SPRITE_ROW + 33);
  assign row_off_s = row - 12'(SPRITE_ROW + 1);

  for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_col
    localparam int LEFT = SPRITE_COLUMN + BARRIER_PITCH * b;
    assign col_hit_s[b] = (32'(col) > LEFT) && (32'(col) < LEFT + 41);
    assign col_off_s[b] = col - 12'(LEFT + 1);
  end

  // Pick the barrier whose bounding box contains the pixel, if any.
  always_comb begin
    addr = '0;
    for (int b = NUM_BARRIERS - 1; b >= 0; b--) begin
      if (row_hit_s && col_hit_s[b]) begin
        addr.barrier  = 2'(b);
        addr.row      = row_off_s[4:2];
        addr.col      = col_off_s[b][5:2];
        addr.in_range = 1'b1;
      end else begin
        addr = addr;
      end
    end
  end

endmodule

// File: rtl/barrier_damage.sv
// Barrier cell map: render lookup, bullet hit/erase FSM, wave restore.
import barrier_pkg::*;

module barrier_damage #(
  parameter int SPRITE_ROW    = 380,
  parameter int SPRITE_COLUMN = 120,
  parameter int BARRIER_PITCH = 120,
  parameter bit SPLASH        = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pixel_row,
  input  logic [11:0] pixel_column,
  output logic [3:0]  barrier_output,
  output logic        barrier1_active,
  output logic        barrier2_active,
  output logic        barrier3_active,
  output logic        barrier4_active,
  input  logic        hit_valid,
  output logic        hit_ready,
  input  logic [11:0] hit_row,
  input  logic [11:0] hit_col,
  output logic        hit_done,
  output logic        hit_result,
  input  logic        restore,
  output logic [8:0]  intact_count
);

  barrier_map_t map_r [NUM_BARRIERS];

  cell_addr_t rd_addr_s;
  cell_addr_t hit_addr_s;
  cell_addr_t addr_r;

  logic [3:0] barrier_output_r;
  logic [3:0] active_r;
  logic       hit_ready_r;
  logic       hit_done_r;
  logic       hit_result_r;
  logic [8:0] intact_count_r;
  hit_state_t state_r;
  logic       tgt_r;
  logic       up_r;
  logic       dn_r;

  logic       has_up_s;
  logic       has_dn_s;
  logic [2:0] up_row_s;
  logic [2:0] dn_row_s;
  logic       accept_s;

  barrier_addr_decode #(
    .SPRITE_ROW(SPRITE_ROW), .SPRITE_COLUMN(SPRITE_COLUMN), .BARRIER_PITCH(BARRIER_PITCH)
  ) u_render_decode (
    .row(pixel_row), .col(pixel_column), .addr(rd_addr_s)
  );

  barrier_addr_decode #(
    .SPRITE_ROW(SPRITE_ROW), .SPRITE_COLUMN(SPRITE_COLUMN), .BARRIER_PITCH(BARRIER_PITCH)
  ) u_hit_decode (
    .row(hit_row), .col(hit_col), .addr(hit_addr_s)
  );

  assign has_up_s = SPLASH && (addr_r.row != 3'd0);
  assign has_dn_s = SPLASH && (addr_r.row != 3'd7);
  assign up_row_s = addr_r.row - 3'd1;
  assign dn_row_s = addr_r.row + 3'd1;

  // restore blocks acceptance in the very cycle it is raised.
  assign accept_s = hit_valid && hit_ready_r && !restore;

  assign barrier_output  = barrier_output_r;
  assign barrier1_active = active_r[0];
  assign barrier2_active = active_r[1];
  assign barrier3_active = active_r[2];
  assign barrier4_active = active_r[3];
  assign hit_ready       = hit_ready_r && !restore;
  assign hit_done        = hit_done_r;
  assign hit_result      = hit_result_r;
  assign intact_count    = intact_count_r;

  // Render lookup: registered read of the map, old data on a same-cycle erase.
  always_ff @(posedge clk) begin
    if (rst) begin
      barrier_output_r <= 4'b0000;
      active_r         <= 4'b0000;
    end else begin
      if (rd_addr_s.in_range && map_r[rd_addr_s.barrier][rd_addr_s.row][rd_addr_s.col]) begin
        barrier_output_r <= 4'b1111;
      end else begin
        barrier_output_r <= 4'b0000;
      end
      active_r <= rd_addr_s.in_range ? (4'b0001 << rd_addr_s.barrier) : 4'b0000;
    end
  end

  // Hit FSM with map and intact counter ownership; restore overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BARRIERS; b++) map_r[b] <= INIT_MASK;
      intact_count_r <= INIT_COUNT;
      state_r        <= IDLE;
      hit_ready_r    <= 1'b0;
      hit_done_r     <= 1'b0;
      hit_result_r   <= 1'b0;
      addr_r         <= '0;
      tgt_r          <= 1'b0;
      up_r           <= 1'b0;
      dn_r           <= 1'b0;
    end else if (restore) begin
      for (int b = 0; b < NUM_BARRIERS; b++) map_r[b] <= INIT_MASK;
      intact_count_r <= INIT_COUNT;
      state_r        <= IDLE;
      hit_ready_r    <= 1'b1;
      hit_done_r     <= 1'b0;
      hit_result_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          hit_done_r  <= 1'b0;
          hit_ready_r <= 1'b1;
          if (accept_s) begin
            addr_r      <= hit_addr_s;
            hit_ready_r <= 1'b0;
            state_r     <= CHECK;
          end else begin
            state_r <= IDLE;
          end
        end
        CHECK: begin
          tgt_r   <= addr_r.in_range && map_r[addr_r.barrier][addr_r.row][addr_r.col];
          up_r    <= addr_r.in_range && has_up_s && map_r[addr_r.barrier][up_row_s][addr_r.col];
          dn_r    <= addr_r.in_range && has_dn_s && map_r[addr_r.barrier][dn_row_s][addr_r.col];
          state_r <= ERASE;
        end
        ERASE: begin
          if (tgt_r) begin
            map_r[addr_r.barrier][addr_r.row][addr_r.col] <= 1'b0;
            if (up_r) map_r[addr_r.barrier][up_row_s][addr_r.col] <= 1'b0;
            if (dn_r) map_r[addr_r.barrier][dn_row_s][addr_r.col] <= 1'b0;
            intact_count_r <= intact_count_r - erased_cells(tgt_r, up_r, dn_r);
          end else begin
            intact_count_r <= intact_count_r;
          end
          hit_done_r   <= 1'b1;
          hit_result_r <= tgt_r;
          state_r      <= RESP;
        end
        RESP: begin
          hit_done_r  <= 1'b0;
          hit_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          hit_done_r  <= 1'b0;
          hit_ready_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_barrier_damage.sv
// Directed self-checking bench for barrier_damage.
module tb_barrier_damage;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] pixel_row, pixel_column;
  logic [3:0]  barrier_output;
  logic        barrier1_active, barrier2_active, barrier3_active, barrier4_active;
  logic        hit_valid, hit_ready;
  logic [11:0] hit_row, hit_col;
  logic        hit_done, hit_result, restore;
  logic [8:0]  intact_count;

  int n_checks = 0;
  int n_fail   = 0;

  barrier_damage dut (
    .clk(clk), .rst(rst),
    .pixel_row(pixel_row), .pixel_column(pixel_column),
    .barrier_output(barrier_output),
    .barrier1_active(barrier1_active), .barrier2_active(barrier2_active),
    .barrier3_active(barrier3_active), .barrier4_active(barrier4_active),
    .hit_valid(hit_valid), .hit_ready(hit_ready),
    .hit_row(hit_row), .hit_col(hit_col),
    .hit_done(hit_done), .hit_result(hit_result),
    .restore(restore), .intact_count(intact_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one hit; lat = ticks from accepting edge to hit_done (-1 on timeout).
  task automatic do_hit(input logic [11:0] r, input logic [11:0] c,
                        output int lat, output logic res);
    int w;
    lat = -1;
    res = 1'b0;
    w = 0;
    while (!hit_ready && w < 20) begin
      tick();
      w++;
    end
    if (hit_ready) begin
      hit_row = r;
      hit_col = c;
      hit_valid = 1'b1;
      tick();
      hit_valid = 1'b0;
      for (int i = 1; i <= 10; i++) begin
        if (hit_done) begin
          lat = i;
          res = hit_result;
          break;
        end
        if (i < 10) tick();
      end
      if (lat == -1) w = 0;
      else tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; restore = 1'b0; hit_valid = 1'b0;
    hit_row = 12'd0; hit_col = 12'd0;
    pixel_row = 12'd385; pixel_column = 12'd125;
    tick(); tick();
    n_checks++;
    if (hit_ready !== 1'b0 || hit_done !== 1'b0 || barrier_output !== 4'b0000 || barrier1_active !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b done=%b out=%b act=%b, expected all 0",
               hit_ready, hit_done, barrier_output, barrier1_active);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (hit_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", hit_ready);
    end
    n_checks++;
    if (intact_count !== 9'd248) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 248", intact_count);
    end
  endtask

  task automatic test_render();
    pixel_row = 12'd385; pixel_column = 12'd125;   // barrier 0 cell (1,1)
    tick();
    n_checks++;
    if (barrier_output !== 4'b1111 || {barrier4_active, barrier3_active, barrier2_active, barrier1_active} !== 4'b0001) begin
      n_fail++; $display("FAIL render_intact: out=%b act=%b%b%b%b expected 1111 / 0001",
                         barrier_output, barrier4_active, barrier3_active, barrier2_active, barrier1_active);
    end
    pixel_row = 12'd381; pixel_column = 12'd121;   // masked corner (0,0)
    tick();
    n_checks++;
    if (barrier_output !== 4'b0000 || barrier1_active !== 1'b1) begin
      n_fail++; $display("FAIL render_corner: out=%b act=%b expected 0000 / 1", barrier_output, barrier1_active);
    end
    pixel_row = 12'd381; pixel_column = 12'd120;   // one column left of box
    tick();
    n_checks++;
    if (barrier_output !== 4'b0000 || barrier1_active !== 1'b0) begin
      n_fail++; $display("FAIL render_edge: out=%b act=%b expected 0000 / 0", barrier_output, barrier1_active);
    end
    pixel_row = 12'd412; pixel_column = 12'd400;   // barrier 2 cell (7,9) intact
    tick();
    n_checks++;
    if (barrier_output !== 4'b1111 || barrier3_active !== 1'b1 || barrier1_active !== 1'b0) begin
      n_fail++; $display("FAIL render_b2: out=%b act3=%b act1=%b expected 1111 / 1 / 0",
                         barrier_output, barrier3_active, barrier1_active);
    end
  endtask

  task automatic test_hit();
    int lat; logic res;
    do_hit(12'd385, 12'd125, lat, res);
    n_checks++;
    if (lat !== 3 || res !== 1'b1) begin
      n_fail++; $display("FAIL hit_first: lat=%0d res=%b expected 3 / 1", lat, res);
    end
    n_checks++;
    if (intact_count !== 9'd245) begin
      n_fail++; $display("FAIL hit_count: got %0d expected 245", intact_count);
    end
    pixel_row = 12'd385; pixel_column = 12'd125;
    tick();
    n_checks++;
    if (barrier_output !== 4'b0000) begin
      n_fail++; $display("FAIL hit_render_target: got %b expected 0000", barrier_output);
    end
    pixel_row = 12'd381;                          // splash above (0,1)
    tick();
    n_checks++;
    if (barrier_output !== 4'b0000) begin
      n_fail++; $display("FAIL hit_render_above: got %b expected 0000", barrier_output);
    end
    pixel_row = 12'd393;                          // (3,1) untouched
    tick();
    n_checks++;
    if (barrier_output !== 4'b1111) begin
      n_fail++; $display("FAIL hit_render_row3: got %b expected 1111", barrier_output);
    end
  endtask

  task automatic test_miss();
    int lat; logic res;
    do_hit(12'd385, 12'd125, lat, res);
    n_checks++;
    if (lat !== 3 || res !== 1'b0 || intact_count !== 9'd245) begin
      n_fail++; $display("FAIL miss_repeat: lat=%0d res=%b cnt=%0d expected 3 / 0 / 245", lat, res, intact_count);
    end
    do_hit(12'd381, 12'd121, lat, res);
    n_checks++;
    if (lat !== 3 || res !== 1'b0 || intact_count !== 9'd245) begin
      n_fail++; $display("FAIL miss_corner: lat=%0d res=%b cnt=%0d expected 3 / 0 / 245", lat, res, intact_count);
    end
    do_hit(12'd500, 12'd300, lat, res);
    n_checks++;
    if (lat !== 3 || res !== 1'b0 || intact_count !== 9'd245) begin
      n_fail++; $display("FAIL miss_outside: lat=%0d res=%b cnt=%0d expected 3 / 0 / 245", lat, res, intact_count);
    end
  endtask

  task automatic test_bottom_edge();
    int lat; logic res;
    // barrier 3, row offset 29 -> cell row 7, col offset 4 -> cell col 1
    do_hit(12'd410, 12'd485, lat, res);
    n_checks++;
    if (lat !== 3 || res !== 1'b1 || intact_count !== 9'd243) begin
      n_fail++; $display("FAIL bottom_hit: lat=%0d res=%b cnt=%0d expected 3 / 1 / 243", lat, res, intact_count);
    end
    pixel_row = 12'd406; pixel_column = 12'd485;  // (6,1) cleared by splash
    tick();
    n_checks++;
    if (barrier_output !== 4'b0000 || barrier4_active !== 1'b1) begin
      n_fail++; $display("FAIL bottom_above: out=%b act4=%b expected 0000 / 1", barrier_output, barrier4_active);
    end
    pixel_row = 12'd402;                          // (5,1) untouched
    tick();
    n_checks++;
    if (barrier_output !== 4'b1111) begin
      n_fail++; $display("FAIL bottom_row5: got %b expected 1111", barrier_output);
    end
  endtask

  task automatic test_restore();
    int done_seen;
    hit_row = 12'd397; hit_col = 12'd141;          // barrier 0 cell (4,5)
    hit_valid = 1'b1;
    tick();                                        // accepted -> CHECK
    hit_valid = 1'b0;
    tick();                                        // ERASE
    restore = 1'b1;
    #1;
    n_checks++;
    if (hit_ready !== 1'b0) begin
      n_fail++; $display("FAIL restore_ready_erase: got %b expected 0", hit_ready);
    end
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (hit_done) done_seen++;
      n_checks++;
      if (hit_ready !== 1'b0) begin
        n_fail++; $display("FAIL restore_ready_held: cycle %0d got %b expected 0", i, hit_ready);
      end
    end
    n_checks++;
    if (intact_count !== 9'd248) begin
      n_fail++; $display("FAIL restore_count: got %0d expected 248", intact_count);
    end
    restore = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (hit_done) done_seen++;
    end
    n_checks++;
    if (done_seen !== 0 || hit_ready !== 1'b1) begin
      n_fail++; $display("FAIL restore_drop: done_pulses=%0d ready=%b expected 0 / 1", done_seen, hit_ready);
    end
    pixel_row = 12'd385; pixel_column = 12'd125;
    tick();
    n_checks++;
    if (barrier_output !== 4'b1111) begin
      n_fail++; $display("FAIL restore_map: got %b expected 1111", barrier_output);
    end
  endtask

  task automatic test_read_before_write();
    hit_row = 12'd385; hit_col = 12'd125;
    pixel_row = 12'd385; pixel_column = 12'd125;
    hit_valid = 1'b1;
    tick();                                        // CHECK
    hit_valid = 1'b0;
    tick();                                        // ERASE: lookup sampled this cycle
    tick();                                        // RESP
    n_checks++;
    if (barrier_output !== 4'b1111 || hit_done !== 1'b1) begin
      n_fail++; $display("FAIL rbw_old: out=%b done=%b expected 1111 / 1", barrier_output, hit_done);
    end
    tick();
    n_checks++;
    if (barrier_output !== 4'b0000 || intact_count !== 9'd245) begin
      n_fail++; $display("FAIL rbw_new: out=%b cnt=%0d expected 0000 / 245", barrier_output, intact_count);
    end
  endtask

  task automatic test_back_to_back();
    int accepts, dones, prev_done, adj;
    accepts = 0; dones = 0; prev_done = 0; adj = 0;
    hit_row = 12'd500; hit_col = 12'd300;
    hit_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (hit_ready) accepts++;
      tick();
      if (hit_done) begin
        dones++;
        if (prev_done != 0) adj++;
      end
      prev_done = int'(hit_done);
    end
    hit_valid = 1'b0;
    n_checks++;
    if (accepts !== 3 || dones !== 3 || adj !== 0) begin
      n_fail++; $display("FAIL back_to_back: accepts=%0d dones=%0d adjacent=%0d expected 3 / 3 / 0",
                         accepts, dones, adj);
    end
    tick();
    n_checks++;
    if (intact_count !== 9'd245 || hit_ready !== 1'b1) begin
      n_fail++; $display("FAIL back_to_back_end: cnt=%0d ready=%b expected 245 / 1", intact_count, hit_ready);
    end
  endtask

  initial begin
    test_reset();
    test_render();
    test_hit();
    test_miss();
    test_bottom_edge();
    test_restore();
    test_read_before_write();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
